// File: rtl/mc_pkg.sv
// mc_pkg: states, opcodes and control encodings for the multicycle controller; MC_CTRL_ZEXT_EN enables andi/ori
package mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
`ifdef MC_CTRL_ZEXT_EN
    localparam bit ZEXT_EN = 1'b1;
`else
    localparam bit ZEXT_EN = 1'b0;
`endif
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_zero;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;
    // Only true when the zero-extending logical immediates are built in.
    function automatic logic is_logic_imm(input logic [5:0] op);
        return ZEXT_EN && (op == OP_ANDI || op == OP_ORI);
    endfunction
endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: combinational map from state, opcode and mem_ready to datapath controls
module mc_out_decode
    import mc_pkg::*;
#(
    parameter int OPW = 6
) (
    input  state_t         i_state,
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_mem_ready,
    output ctrl_t          o_ctrl
);
    logic w_logic;
    assign w_logic = is_logic_imm(i_opcode);
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: o_ctrl.alu_src_b = SRCB_IMM_SL2;
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_RTEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_src        = PC_ALUOUT;
            end
            S_IEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = w_logic ? ALU_LOGIC : ALU_ADD;
                o_ctrl.ext_zero  = w_logic;
            end
            // IR still holds the opcode, so the ALU setup of IEX carries over.
            S_IWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = w_logic ? ALU_LOGIC : ALU_ADD;
                o_ctrl.ext_zero  = w_logic;
            end
            S_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = PC_JUMP;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS-subset controller; define MC_CTRL_ZEXT_EN to make andi/ori legal
module mc_ctrl_fsm #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_read,
    output logic           mem_write,
    output logic           iord,
    output logic           ir_write,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic [1:0]     pc_src,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           ext_zero,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           illegal,
    output logic [STW-1:0] state_o
);
    import mc_pkg::*;
    state_t r_state, w_next;
    logic   r_illegal;
    ctrl_t  w_ctrl, w_out;
    logic   w_unused_zero;
    // The branch decision happens in the datapath via pc_write_cond.
    assign w_unused_zero = zero;
    mc_out_decode #(.OPW(OPW)) u_dec (
        .i_state    (r_state),
        .i_opcode   (opcode),
        .i_mem_ready(mem_ready),
        .o_ctrl     (w_ctrl)
    );
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     w_next = S_MEMADR;
                    OP_RTYPE:         w_next = S_RTEX;
                    OP_BEQ:           w_next = S_BEQ;
                    OP_ADDI:          w_next = S_IEX;
                    OP_J:             w_next = S_JUMP;
                    OP_ANDI, OP_ORI:  w_next = ZEXT_EN ? S_IEX : S_TRAP;
                    default:          w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   w_next = S_RTWB;
            S_IEX:    w_next = S_IWB;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        r_state   <= rst ? S_FETCH : w_next;
        r_illegal <= rst ? 1'b0 : (r_illegal | (w_next == S_TRAP));
    end
    assign w_out         = rst ? '0 : w_ctrl;
    assign mem_read      = w_out.mem_read;
    assign mem_write     = w_out.mem_write;
    assign iord          = w_out.iord;
    assign ir_write      = w_out.ir_write;
    assign pc_write      = w_out.pc_write;
    assign pc_write_cond = w_out.pc_write_cond;
    assign pc_src        = w_out.pc_src;
    assign alu_src_a     = w_out.alu_src_a;
    assign alu_src_b     = w_out.alu_src_b;
    assign alu_op        = w_out.alu_op;
    assign ext_zero      = w_out.ext_zero;
    assign reg_dst       = w_out.reg_dst;
    assign mem_to_reg    = w_out.mem_to_reg;
    assign reg_write     = w_out.reg_write;
    assign illegal       = r_illegal & ~rst;
    assign state_o       = rst ? STW'(S_FETCH) : STW'(r_state);
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed and randomized checks of mc_ctrl_fsm against an instruction-path model
module tb_mc_ctrl_fsm;
`ifdef MC_CTRL_ZEXT_EN
    localparam bit ZEXT = 1'b1;
`else
    localparam bit ZEXT = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = '0;
    logic mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, alu_src_a;
    logic ext_zero, reg_dst, mem_to_reg, reg_write, illegal;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state_o;
    logic [17:0] act;
    int checks = 0, errors = 0;
    int path[$];
    always #5 clk = ~clk;
    assign act = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
                  alu_src_a, alu_src_b, alu_op, ext_zero, reg_dst, mem_to_reg, reg_write, illegal};
    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_zero(ext_zero),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal(illegal), .state_o(state_o)
    );
    // Control table per state, in the same bit order as act.
    function automatic logic [17:0] exp_out(int st, logic [5:0] op, logic rdy);
        logic mr, mw, io, irw, pw, pwc, asa, ez, rd, m2r, rw, il, lg;
        logic [1:0] ps, asb, ao;
        {mr, mw, io, irw, pw, pwc, asa, ez, rd, m2r, rw, il} = '0;
        {ps, asb, ao} = '0;
        lg = ZEXT && (op == 6'b001100 || op == 6'b001101);
        case (st)
            0: begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            1: asb = 2'b11;
            2: begin asa = 1; asb = 2'b10; end
            3: begin mr = 1; io = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mw = 1; io = 1; end
            6: begin asa = 1; ao = 2'b10; end
            7: begin rw = 1; rd = 1; end
            8: begin asa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            9: begin asa = 1; asb = 2'b10; ao = lg ? 2'b11 : 2'b00; ez = lg; end
            10: begin rw = 1; ao = lg ? 2'b11 : 2'b00; ez = lg; end
            11: begin pw = 1; ps = 2'b10; end
            12: il = 1;
            default: ;
        endcase
        return {mr, mw, io, irw, pw, pwc, ps, asa, asb, ao, ez, rd, m2r, rw, il};
    endfunction
    // Sequence of states one instruction visits, ignoring stalls.
    function automatic void set_path(logic [5:0] op);
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b000100: path = '{0, 1, 8};
            6'b001000: path = '{0, 1, 9, 10};
            6'b000010: path = '{0, 1, 11};
            6'b001100, 6'b001101: path = ZEXT ? '{0, 1, 9, 10} : '{0, 1, 12};
            default: path = '{0, 1, 12};
        endcase
    endfunction
    task automatic test_reset;
        rst = 1'b1;
        opcode = 6'b100011;
        for (int c = 0; c < 2; c++) begin
            mem_ready = 1'($urandom);
            #1;
            checks++;
            if (state_o !== 4'd0 || act !== 18'd0) begin
                errors++;
                $display("FAIL reset cyc %0d: state %0d out %h, expected 0 out 0", c, state_o, act);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask
    task automatic test_lw;
        int st[6] = '{0, 1, 2, 3, 4, 0};
        logic rdy[6] = '{1, 1, 1, 1, 1, 0};
        opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state_o !== 4'(st[i]) || act !== exp_out(st[i], opcode, rdy[i])) begin
                errors++;
                $display("FAIL lw cyc %0d: state %0d out %h, expected state %0d out %h",
                         i, state_o, act, st[i], exp_out(st[i], opcode, rdy[i]));
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_sw_stall;
        int st[8] = '{0, 1, 2, 5, 5, 5, 5, 0};
        logic rdy[8] = '{1, 1, 1, 0, 0, 0, 1, 0};
        opcode = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state_o !== 4'(st[i]) || act !== exp_out(st[i], opcode, rdy[i])) begin
                errors++;
                $display("FAIL sw_stall cyc %0d: state %0d out %h, expected state %0d out %h",
                         i, state_o, act, st[i], exp_out(st[i], opcode, rdy[i]));
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_beq;
        int st[4] = '{0, 1, 8, 0};
        logic rdy[4] = '{1, 1, 1, 0};
        opcode = 6'b000100;
        zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state_o !== 4'(st[i]) || act !== exp_out(st[i], opcode, rdy[i])) begin
                errors++;
                $display("FAIL beq cyc %0d: state %0d out %h, expected state %0d out %h",
                         i, state_o, act, st[i], exp_out(st[i], opcode, rdy[i]));
            end
            @(posedge clk); #1;
        end
        zero = 1'b0;
    endtask
    task automatic test_andi;
        int st[5];
        logic rdy[5] = '{1, 1, 1, 1, 0};
        st = ZEXT ? '{0, 1, 9, 10, 0} : '{0, 1, 12, 12, 12};
        opcode = 6'b001100;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state_o !== 4'(st[i]) || act !== exp_out(st[i], opcode, rdy[i])) begin
                errors++;
                $display("FAIL andi cyc %0d: state %0d out %h, expected state %0d out %h",
                         i, state_o, act, st[i], exp_out(st[i], opcode, rdy[i]));
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
    endtask
    task automatic test_trap;
        opcode = 6'b111111;
        for (int i = 0; i < 12; i++) begin
            int st;
            st = (i < 2) ? i : 12;
            mem_ready = (i < 2) ? 1'b1 : 1'($urandom);
            #1;
            checks++;
            if (state_o !== 4'(st) || act !== exp_out(st, opcode, mem_ready)) begin
                errors++;
                $display("FAIL trap cyc %0d: state %0d out %h, expected state %0d out %h",
                         i, state_o, act, st, exp_out(st, opcode, mem_ready));
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || act !== 18'd0) begin
            errors++;
            $display("FAIL trap_rst_hold: state %0d out %h, expected 0 out 0", state_o, act);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL trap_cleared: state %0d illegal %b, expected state 0 illegal 0", state_o, illegal);
        end
        @(posedge clk); #1;
    endtask
    task automatic test_reset_midstall;
        int st[5] = '{0, 1, 2, 3, 3};
        logic rdy[5] = '{1, 1, 1, 0, 0};
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state_o !== 4'(st[i]) || act !== exp_out(st[i], opcode, rdy[i])) begin
                errors++;
                $display("FAIL midstall cyc %0d: state %0d out %h, expected state %0d out %h",
                         i, state_o, act, st[i], exp_out(st[i], opcode, rdy[i]));
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || mem_read !== 1'b1 || iord !== 1'b0) begin
            errors++;
            $display("FAIL midstall_rst: state %0d mem_read %b iord %b, expected 0 1 0", state_o, mem_read, iord);
        end
        @(posedge clk); #1;
    endtask
    task automatic test_random;
        logic [5:0] ops[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b001000, 6'b000010, 6'b001100, 6'b001101};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            int idx, trap_cyc, st;
            logic rdy;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            set_path(op);
            opcode = op;
            idx = 0;
            trap_cyc = 0;
            for (int c = 0; c < 64 && idx < path.size(); c++) begin
                st = path[idx];
                rdy = ($urandom_range(0, 3) != 0);
                mem_ready = rdy;
                zero = 1'($urandom);
                #1;
                checks++;
                if (state_o !== 4'(st) || act !== exp_out(st, op, rdy)) begin
                    errors++;
                    $display("FAIL random op %b cyc %0d: state %0d out %h, expected state %0d out %h",
                             op, c, state_o, act, st, exp_out(st, op, rdy));
                end
                if (st == 12) begin
                    trap_cyc++;
                    if (trap_cyc == 3) idx = path.size();
                end else if (!((st == 0 || st == 3 || st == 5) && !rdy)) idx++;
                @(posedge clk); #1;
            end
            if (trap_cyc != 0) begin
                rst = 1'b1;
                mem_ready = 1'($urandom);
                #1;
                checks++;
                if (state_o !== 4'd0 || act !== 18'd0) begin
                    errors++;
                    $display("FAIL random_rst: state %0d out %h, expected 0 out 0", state_o, act);
                end
                @(posedge clk); #1;
                rst = 1'b0;
            end
        end
    endtask
    initial begin
        test_reset;
        test_lw;
        test_sw_stall;
        test_beq;
        test_andi;
        test_trap;
        test_reset_midstall;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
